// File: rtl/acia_pkg.sv
// Shared ACIA constants: serial timing and receive FIFO defaults.
package acia_pkg;

  localparam int CLK_FREQ = 24_000_000;
  localparam int SYM_RATE = 115_200;
  // Rounded to the nearest whole clock count per symbol.
  localparam int SYM_CNT  = (CLK_FREQ + SYM_RATE / 2) / SYM_RATE;

  localparam int RXF_DEPTH  = 16;
  localparam int RXF_THRESH = 8;

  typedef struct packed {
    logic       err;
    logic [7:0] dat;
  } rxf_entry_t;

  function automatic int rxf_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acia_rx_fifo_if.sv
// Receive FIFO bus: receiver-side push, CPU-side pop and status.
interface acia_rx_fifo_if
  import acia_pkg::*;
#(
    parameter int DEPTH = RXF_DEPTH
);
    localparam int CW = rxf_cnt_w(DEPTH);

    // Strobes are one-cycle events, not valid/ready pairs: wr_stb pushes unless
    // full with no pop that cycle; rd_stb pops unless empty; no back-pressure.
    logic          flush;
    logic [7:0]    wr_dat;
    logic          wr_err;
    logic          wr_stb;
    logic          rd_stb;
    logic          ovr_clr;
    logic [7:0]    rd_dat;
    logic          rd_err;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          ovr;
    logic          lvl_irq;

    modport master (
        output flush, wr_dat, wr_err, wr_stb, rd_stb, ovr_clr,
        input  rd_dat, rd_err, empty, full, count, ovr, lvl_irq
    );

    modport slave (
        input  flush, wr_dat, wr_err, wr_stb, rd_stb, ovr_clr,
        output rd_dat, rd_err, empty, full, count, ovr, lvl_irq
    );

endinterface

// File: rtl/acia_rx_fifo.sv
// ACIA receive FIFO: first-word-fall-through circular buffer of {err, byte}
// entries with sticky overrun and fill-level interrupt.
module acia_rx_fifo
  import acia_pkg::*;
#(
    parameter int DEPTH  = RXF_DEPTH,
    parameter int THRESH = RXF_THRESH
) (
    input  logic           clk,
    input  logic           rst,
    acia_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rxf_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovr_q;
    rxf_entry_t    hold_q;
    rxf_entry_t    head;

    logic empty_w;
    logic full_w;
    logic do_push;
    logic do_pop;
    logic overrun;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a
    // push when rd_stb is high; flush drops any concurrent push or pop.
    always_comb begin
        empty_w = (cnt == '0);
        full_w  = (cnt == CW'(DEPTH));
        do_pop  = !bus.flush && bus.rd_stb && !empty_w;
        do_push = !bus.flush && bus.wr_stb && (!full_w || do_pop);
        overrun = bus.wr_stb && full_w && !bus.rd_stb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr_q  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            // A new overrun wins over a clear in the same cycle.
            if (overrun)          ovr_q <= 1'b1;
            else if (bus.ovr_clr) ovr_q <= 1'b0;
        end
    end

    // Storage carries no reset so it maps onto distributed registers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{err: bus.wr_err, dat: bus.wr_dat};
    end

    // Tracks the current head so the outputs keep their last value once empty.
    always_ff @(posedge clk) begin
        if (rst)           hold_q <= '0;
        else if (!empty_w) hold_q <= mem[rd_ptr];
    end

    always_comb begin
        head = empty_w ? hold_q : mem[rd_ptr];
    end

    assign bus.rd_dat  = head.dat;
    assign bus.rd_err  = head.err;
    assign bus.empty   = empty_w;
    assign bus.full    = full_w;
    assign bus.count   = cnt;
    assign bus.ovr     = ovr_q;
    assign bus.lvl_irq = (cnt >= CW'(THRESH));

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Bench for acia_rx_fifo: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_acia_rx_fifo;
  import acia_pkg::*;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_miscmp = 0;
  logic [8:0] exp_q[$];

  acia_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  acia_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.flush = 1'b0;  bus.wr_dat = 8'h00; bus.wr_err = 1'b0;
    bus.wr_stb = 1'b0; bus.rd_stb = 1'b0;  bus.ovr_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // drivers: inputs change just after a falling edge, outputs are read at the next one
  task automatic step(input logic ws, input logic [7:0] d, input logic e, input logic rs);
    bus.wr_stb = ws; bus.wr_dat = d; bus.wr_err = e; bus.rd_stb = rs;
    @(negedge clk);
    bus.wr_stb = 1'b0; bus.rd_stb = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    step(1'b1, d, e, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    push(8'h5A, 1'b1);
    push(8'h5B, 1'b0);
    do_reset();
    n_vec++;
    if (bus.count !== CW'(0)) begin
      n_miscmp++; $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    n_vec++;
    if ({bus.empty, bus.full, bus.ovr, bus.lvl_irq} !== 4'b1000) begin
      n_miscmp++;
      $display("FAIL reset_flags: got empty/full/ovr/lvl=%b want 1000",
               {bus.empty, bus.full, bus.ovr, bus.lvl_irq});
    end
    n_vec++;
    if ({bus.rd_err, bus.rd_dat} !== 9'h000) begin
      n_miscmp++; $display("FAIL reset_head: got %h want 000", {bus.rd_err, bus.rd_dat});
    end
  endtask

  task automatic test_order();
    do_reset();
    push(8'h41, 1'b0);
    n_vec++;
    if ({bus.empty, bus.rd_dat} !== {1'b0, 8'h41}) begin
      n_miscmp++;
      $display("FAIL order_latency: got empty=%b dat=%h want 0/41", bus.empty, bus.rd_dat);
    end
    push(8'h42, 1'b0);
    push(8'h43, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({bus.count, bus.rd_dat} !== {CW'(3 - i), 8'(8'h41 + i)}) begin
        n_miscmp++;
        $display("FAIL order_pop%0d: got count=%0d dat=%h want %0d/%h",
                 i, bus.count, bus.rd_dat, 3 - i, 8'h41 + i);
      end
      pop();
    end
    n_vec++;
    if ({bus.count, bus.empty, bus.rd_dat} !== {CW'(0), 1'b1, 8'h43}) begin
      n_miscmp++;
      $display("FAIL order_end: got count=%0d empty=%b dat=%h want 0/1/43",
               bus.count, bus.empty, bus.rd_dat);
    end
    pop();
    n_vec++;
    if (bus.count !== CW'(0)) begin
      n_miscmp++; $display("FAIL order_pop_empty: got count=%0d want 0", bus.count);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    n_vec++;
    if ({bus.full, bus.ovr, bus.count} !== {1'b1, 1'b0, CW'(DEPTH)}) begin
      n_miscmp++;
      $display("FAIL ovr_fill: got full=%b ovr=%b count=%0d want 1/0/%0d",
               bus.full, bus.ovr, bus.count, DEPTH);
    end
    push(8'hAA, 1'b0);
    n_vec++;
    if ({bus.full, bus.ovr, bus.count} !== {1'b1, 1'b1, CW'(DEPTH)}) begin
      n_miscmp++;
      $display("FAIL ovr_set: got full=%b ovr=%b count=%0d want 1/1/%0d",
               bus.full, bus.ovr, bus.count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (bus.rd_dat !== 8'(i)) begin
        n_miscmp++; $display("FAIL ovr_drain%0d: got %h want %h", i, bus.rd_dat, 8'(i));
      end
      pop();
    end
    n_vec++;
    if ({bus.empty, bus.ovr} !== 2'b11) begin
      n_miscmp++; $display("FAIL ovr_sticky: got empty=%b ovr=%b want 1/1", bus.empty, bus.ovr);
    end
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    n_vec++;
    if (bus.ovr !== 1'b0) begin
      n_miscmp++; $display("FAIL ovr_clr: got %b want 0", bus.ovr);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    n_vec++;
    if ({bus.count, bus.ovr, bus.full} !== {CW'(DEPTH), 1'b0, 1'b1}) begin
      n_miscmp++;
      $display("FAIL fullpp_state: got count=%0d ovr=%b full=%b want %0d/0/1",
               bus.count, bus.ovr, bus.full, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      want = (i == DEPTH - 1) ? 8'h55 : 8'(8'h21 + i);
      n_vec++;
      if (bus.rd_dat !== want) begin
        n_miscmp++; $display("FAIL fullpp_drain%0d: got %h want %h", i, bus.rd_dat, want);
      end
      pop();
    end
    // overrun and clear in the same cycle keep ovr set
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    bus.ovr_clr = 1'b1;
    push(8'hBB, 1'b0);
    bus.ovr_clr = 1'b0;
    n_vec++;
    if (bus.ovr !== 1'b1) begin
      n_miscmp++; $display("FAIL clr_vs_ovr: got ovr=%b want 1", bus.ovr);
    end
  endtask

  task automatic test_lvl_irq();
    do_reset();
    for (int i = 0; i < THRESH - 1; i++) push(8'(i), 1'b0);
    n_vec++;
    if (bus.lvl_irq !== 1'b0) begin
      n_miscmp++; $display("FAIL lvl_below: got %b want 0", bus.lvl_irq);
    end
    push(8'hC0, 1'b0);
    n_vec++;
    if (bus.lvl_irq !== 1'b1) begin
      n_miscmp++; $display("FAIL lvl_rise: got %b want 1", bus.lvl_irq);
    end
    pop();
    n_vec++;
    if (bus.lvl_irq !== 1'b0) begin
      n_miscmp++; $display("FAIL lvl_fall: got %b want 0", bus.lvl_irq);
    end
  endtask

  task automatic test_err_flag();
    do_reset();
    push(8'hFF, 1'b1);
    push(8'h10, 1'b0);
    n_vec++;
    if ({bus.rd_err, bus.rd_dat} !== 9'h1FF) begin
      n_miscmp++; $display("FAIL err_head: got %h want 1ff", {bus.rd_err, bus.rd_dat});
    end
    pop();
    n_vec++;
    if ({bus.rd_err, bus.rd_dat} !== 9'h010) begin
      n_miscmp++; $display("FAIL err_next: got %h want 010", {bus.rd_err, bus.rd_dat});
    end
  endtask

  task automatic test_flush_rst();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) push(8'(8'h30 + i), 1'b0);
      push(8'hEE, 1'b0);
      for (int i = 0; i < DEPTH - 5; i++) pop();
      n_vec++;
      if ({bus.count, bus.ovr} !== {CW'(5), 1'b1}) begin
        n_miscmp++;
        $display("FAIL clean%0d_pre: got count=%0d ovr=%b want 5/1", k, bus.count, bus.ovr);
      end
      if (k == 0) bus.flush = 1'b1;
      else        rst = 1'b1;
      push(8'h77, 1'b0);
      bus.flush = 1'b0;
      rst = 1'b0;
      n_vec++;
      if ({bus.count, bus.empty, bus.ovr} !== {CW'(0), 1'b1, 1'b0}) begin
        n_miscmp++;
        $display("FAIL clean%0d_state: got count=%0d empty=%b ovr=%b want 0/1/0",
                 k, bus.count, bus.empty, bus.ovr);
      end
      push(8'h99, 1'b0);
      n_vec++;
      if ({bus.count, bus.rd_dat} !== {CW'(1), 8'h99}) begin
        n_miscmp++;
        $display("FAIL clean%0d_dropped: got count=%0d dat=%h want 1/99", k, bus.count, bus.rd_dat);
      end
    end
  endtask

  task automatic test_random();
    logic ws, rs, fl, clr, e, full_now, m_ovr;
    logic [7:0] d;
    logic [8:0] m_last;
    logic [CW+12:0] exp_v, got_v;
    int wp;
    do_reset();
    exp_q.delete();
    m_ovr = 1'b0;
    m_last = 9'h000;
    for (int i = 0; i < 900; i++) begin
      wp  = (i < 300) ? 80 : (i < 600) ? 25 : 55;
      ws  = ($urandom_range(99) < wp);
      rs  = ($urandom_range(99) < (100 - wp));
      fl  = ($urandom_range(149) == 0);
      clr = ($urandom_range(19) == 0);
      d   = 8'($urandom);
      e   = 1'($urandom_range(1));
      // reference: pop first so a full FIFO can accept a same-cycle push
      if (fl) begin
        exp_q.delete();
        m_ovr = 1'b0;
      end else begin
        full_now = (exp_q.size() == DEPTH);
        if (ws && full_now && !rs) m_ovr = 1'b1;
        else if (clr)              m_ovr = 1'b0;
        if (rs && exp_q.size() > 0) void'(exp_q.pop_front());
        if (ws && (!full_now || rs)) exp_q.push_back({e, d});
      end
      if (exp_q.size() > 0) m_last = exp_q[0];
      bus.flush = fl;
      bus.ovr_clr = clr;
      step(ws, d, e, rs);
      bus.flush = 1'b0;
      bus.ovr_clr = 1'b0;
      exp_v = {CW'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH,
               exp_q.size() >= THRESH, m_ovr, m_last};
      got_v = {bus.count, bus.empty, bus.full, bus.lvl_irq, bus.ovr, bus.rd_err, bus.rd_dat};
      n_vec++;
      if (got_v !== exp_v) begin
        n_miscmp++;
        $display("FAIL random%0d: got cnt/emp/full/lvl/ovr/head=%h want %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_order();
    test_overrun();
    test_full_push_pop();
    test_lvl_irq();
    test_err_flag();
    test_flush_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/acia_rx_fifo.md
ACIA_RX_FIFO -- requirements
Module: acia_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, shall set the number of entries; it shall be a power of two, 4..64.
REQ-002 Parameter THRESH, default 8, shall set the fill level that raises lvl_irq; range 1..DEPTH.
REQ-003 clk  input  1  system clock (24 MHz).
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  discard all contents, synchronous.
REQ-006 wr_dat  input  8  received byte from the serial receiver.
REQ-007 wr_err  input  1  framing/error flag accompanying wr_dat.
REQ-008 wr_stb  input  1  one-cycle push strobe from the receiver.
REQ-009 rd_stb  input  1  one-cycle pop strobe from the CPU-side data-register read.
REQ-010 rd_dat  output  8  head entry byte.
REQ-011 rd_err  output  1  head entry error flag.
REQ-012 empty  output  1  no entries held.
REQ-013 full  output  1  DEPTH entries held.
REQ-014 count  output  $clog2(DEPTH)+1  number of entries held.
REQ-015 ovr  output  1  sticky overrun flag.
REQ-016 ovr_clr  input  1  clears ovr.
REQ-017 lvl_irq  output  1  high while count >= THRESH.

Function
REQ-018 Storage shall be DEPTH 9-bit entries {err, byte}, with a circular buffer, write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 rd_dat/rd_err shall be first-word-fall-through: the oldest entry is visible with no read latency whenever empty=0.
REQ-020 rd_dat/rd_err shall hold their last value while empty=1; no X shall propagate.
REQ-021 A push (wr_stb=1, full=0) shall write the entry at the write pointer and increment it; count shall rise by 1 on the next cycle.
REQ-022 A push is visible at rd_dat on the cycle after wr_stb when the FIFO was empty (1-cycle write-to-read latency).
REQ-023 A pop (rd_stb=1, empty=0) shall increment the read pointer; count shall fall by 1 on the next cycle.
REQ-024 A pop while empty=1 shall be ignored, with no pointer or count change.
REQ-025 Simultaneous push and pop with 0<count<DEPTH shall leave count unchanged and advance both pointers.
REQ-026 A push while full=1 and rd_stb=1 shall be accepted, because the pop frees the slot in the same cycle.
REQ-027 A push while full=1 and rd_stb=0 shall discard the byte, leave contents unchanged, and set ovr on the next cycle.
REQ-028 Simultaneous push and pop while empty=1 shall perform the push only.
REQ-029 ovr shall stay set until ovr_clr, flush or rst; if ovr_clr and a new overrun occur in the same cycle, ovr shall remain set.
REQ-030 flush shall zero both pointers and count and clear ovr on the next cycle; a push in the same cycle shall be dropped.
REQ-031 empty, full and lvl_irq shall be registered or derived only from the registered count; they shall be glitch-free and valid from the cycle after each update.

Reset
REQ-032 On rst the block shall set count=0, both pointers=0, empty=1, full=0, ovr=0, lvl_irq=0, rd_dat=8'h00 and rd_err=0; storage contents need not be cleared.
REQ-033 rst shall take priority over flush, push and pop; reset mid-operation shall discard all entries.

Structure
REQ-034 A shared package acia_pkg shall hold CLK_FREQ=24000000, SYM_RATE=115200 and the derived SYM_CNT, plus the FIFO defaults RXF_DEPTH=16 and RXF_THRESH=8.
REQ-035 The block shall be a single module with no sub-modules; the storage shall be inferable as distributed registers.
REQ-036 The enclosing ACIA shall map empty to status bit 0 (inverted), ovr to the overrun bit, rd_err to the framing bit and lvl_irq into the receive interrupt.

Verification
REQ-037 Push 8'h41, 8'h42, 8'h43 on separate cycles, then pop three times -> rd_dat reads 41, 42, 43 in order; count reads 3,2,1,0; empty=1 at the end.
REQ-038 Push 16 bytes 8'h00..8'h0F, then push 8'hAA -> full=1, ovr=1, count=16; draining returns 00..0F, and AA never appears.
REQ-039 With the FIFO full, push 8'h55 and pop in the same cycle -> count stays 16, ovr=0, and 55 is the last byte drained.
REQ-040 Push 8 bytes -> lvl_irq rises the cycle after the 8th push; one pop -> lvl_irq falls the next cycle.
REQ-041 Push 8'hFF with wr_err=1, then 8'h10 with wr_err=0 -> rd_err=1 at the head; after a pop, rd_err=0 and rd_dat=8'h10.
REQ-042 With 5 entries held and ovr=1, assert flush and a wr_stb together -> next cycle count=0, empty=1, ovr=0, and the pushed byte is absent; repeat the check with rst instead of flush.
